// File: rtl/n8_pkg.sv
// Shared definitions for the N8 pad scanner: button order, scan FSM states,
// default timing constants and a frame-length helper.
package n8_pkg;

  localparam int unsigned NUM_BTNS = 8;

  // Serial bit order as shifted out of an N8 controller.
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    PULSE,
    DONE
  } scan_state_e;

  localparam int unsigned  DEF_POLL_CYC     = 833_333;
  localparam int unsigned  DEF_HALF_CYC     = 300;
  localparam int unsigned  DEF_REPEAT_DELAY = 20;
  localparam int unsigned  DEF_REPEAT_RATE  = 6;
  localparam logic [7:0]   DEF_REPEAT_MASK  = 8'hF0;

  // Cycles from first latch-high cycle through the DONE cycle.
  function automatic int unsigned frame_len(input int unsigned half_cyc);
    return 18 * half_cyc + 1;
  endfunction

endpackage

// File: rtl/n8_repeat_ctr.sv
// Held-frame counter for one auto-repeating button. Counts frames while the
// button is held and flags the first repeat at REPEAT_DELAY and every
// REPEAT_RATE frames after that.
module n8_repeat_ctr #(
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_en,
  input  logic held,
  output logic fire
);

  localparam int unsigned CAP = REPEAT_DELAY + REPEAT_RATE;
  localparam int unsigned CW  = $clog2(CAP + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  // Saturating increment, event decode and reload; counting CAP loops back to
  // REPEAT_DELAY so later events recur every REPEAT_RATE frames without wrap.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q >= CW'(CAP)) ? CW'(CAP) : cnt_q + 1'b1;
    fire    = held && ((cnt_inc == CW'(REPEAT_DELAY)) || (cnt_inc == CW'(CAP)));
    if (frame_en) begin
      if (!held) begin
        cnt_d = '0;
      end else if (cnt_inc == CW'(CAP)) begin
        cnt_d = CW'(REPEAT_DELAY);
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/n8_pad_scanner.sv
// Polls NUM_PADS N8 controllers over a shared latch/pulse pair once per poll
// frame, publishing held levels plus one-cycle press/auto-repeat events.
module n8_pad_scanner
  import n8_pkg::*;
#(
  parameter int unsigned NUM_PADS     = 2,
  parameter int unsigned POLL_CYC     = DEF_POLL_CYC,
  parameter int unsigned HALF_CYC     = DEF_HALF_CYC,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [7:0]  REPEAT_MASK  = DEF_REPEAT_MASK
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_PADS-1:0]   data_in,
  output logic                  latch,
  output logic                  pulse,
  output logic [NUM_PADS*8-1:0] buttons,
  output logic [NUM_PADS*8-1:0] press,
  output logic                  frame_valid
);

  localparam int unsigned NB  = NUM_PADS * NUM_BTNS;
  localparam int unsigned PHW = $clog2(2 * HALF_CYC);
  localparam int unsigned PCW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  if (frame_len(HALF_CYC) >= POLL_CYC) begin : g_bad_timing
    $error("n8_pad_scanner: scan frame does not fit in poll period");
  end
  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
    $error("n8_pad_scanner: NUM_PADS must be 1..4");
  end

  scan_state_e    state_q, state_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [2:0]     bit_q, bit_d;
  logic [PCW-1:0] poll_q, poll_d;
  logic [NB-1:0]  shift_q, shift_d;
  logic [NB-1:0]  buttons_q, buttons_d;
  logic [NB-1:0]  press_q, press_d;
  logic           latch_q, latch_d;
  logic           pulse_q, pulse_d;
  logic           fv_q, fv_d;
  logic           commit;
  logic [NB-1:0]  rep_fire;

  // Scan sequencer and poll counter: next state, phase/bit tracking, sampling.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    poll_d  = (poll_q == PCW'(POLL_CYC - 1)) ? '0 : poll_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (poll_q == '0) begin
          state_d = LATCH;
          phase_d = '0;
        end
      end
      LATCH: begin
        if (phase_q == PHW'(2 * HALF_CYC - 1)) begin
          state_d = SETTLE;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      SETTLE: begin
        if (phase_q == PHW'(HALF_CYC - 1)) begin
          state_d = PULSE;
          phase_d = '0;
          for (int unsigned p = 0; p < NUM_PADS; p++) begin
            shift_d[p * NUM_BTNS + 32'(bit_q)] = ~data_in[p];
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      PULSE: begin
        if (phase_q == PHW'(HALF_CYC - 1)) begin
          phase_d = '0;
          if (bit_q == 3'(BTN_RIGHT)) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SETTLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state so the pad lines never glitch;
  // the frame commits on the single edge that enters DONE.
  always_comb begin
    commit    = (state_d == DONE);
    latch_d   = (state_d == LATCH);
    pulse_d   = (state_d == PULSE);
    fv_d      = commit;
    buttons_d = buttons_q;
    press_d   = '0;
    if (commit) begin
      buttons_d = shift_q;
      press_d   = (shift_q & ~buttons_q) | rep_fire;
    end
  end

  // Per-pad, per-button repeat counters on auto-repeating buttons only.
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      if (REPEAT_MASK[b]) begin : g_rep
        n8_repeat_ctr #(
          .REPEAT_DELAY (REPEAT_DELAY),
          .REPEAT_RATE  (REPEAT_RATE)
        ) u_ctr (
          .clk      (clk),
          .reset_n  (reset_n),
          .frame_en (commit),
          .held     (shift_q[p * NUM_BTNS + b]),
          .fire     (rep_fire[p * NUM_BTNS + b])
        );
      end else begin : g_norep
        assign rep_fire[p * NUM_BTNS + b] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      poll_q    <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      press_q   <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      press_q   <= press_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      fv_q      <= fv_d;
    end
  end

  assign latch       = latch_q;
  assign pulse       = pulse_q;
  assign buttons     = buttons_q;
  assign press       = press_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_n8_pad_scanner.sv
// Bench for n8_pad_scanner: emulated N8 pads, a frame-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_n8_pad_scanner;

  localparam int unsigned NP   = 2;
  localparam int unsigned H    = 4;
  localparam int unsigned POLL = 200;
  localparam int unsigned RD   = 3;
  localparam int unsigned RR   = 2;
  localparam logic [7:0]  MASK = 8'hF0;

  logic          clk;
  logic          reset_n;
  logic [NP-1:0] data_in;
  logic          latch, pulse, frame_valid;
  logic [15:0]   buttons, press;

  n8_pad_scanner #(
    .NUM_PADS     (NP),
    .POLL_CYC     (POLL),
    .HALF_CYC     (H),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .REPEAT_MASK  (MASK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .latch       (latch),
    .pulse       (pulse),
    .buttons     (buttons),
    .press       (press),
    .frame_valid (frame_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pad emulator: latch reloads the shift register, each pulse rise advances it.
  logic [7:0]  pat [NP];
  logic        force_zero;
  int unsigned idx = 0;
  logic        pulse_seen = 1'b0;

  always @(posedge clk) begin
    pulse_seen <= pulse;
    if (latch === 1'b1) idx <= 0;
    else if (pulse === 1'b1 && pulse_seen !== 1'b1 && idx < 8) idx <= idx + 1;
  end

  always_comb begin
    data_in = '0;
    for (int p = 0; p < NP; p++) begin
      if (force_zero) data_in[p] = 1'b0;
      else if (idx < 8) data_in[p] = ~pat[p][idx[2:0]];
      else data_in[p] = 1'b1;
    end
  end

  // Reference model: frame timeline from cycles since reset release, and
  // per-button held-frame counts with event rules stated arithmetically.
  int unsigned cyc = 0;
  bit          started = 0;
  int unsigned hold [NP][8];
  logic [15:0] exp_btn, exp_press;
  logic        exp_latch, exp_pulse, exp_fv;
  logic        r_s;
  int unsigned f;
  bit          ev;

  always begin
    @(posedge clk);
    r_s = reset_n;
    #2;
    if (r_s !== 1'b1) begin
      started   = 1;
      cyc       = 0;
      exp_btn   = '0;
      exp_press = '0;
      exp_latch = 1'b0;
      exp_pulse = 1'b0;
      exp_fv    = 1'b0;
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < 8; b++) hold[p][b] = 0;
    end else if (started) begin
      cyc++;
      f = (cyc - 1) % POLL;
      exp_latch = (f < 2 * H);
      exp_pulse = (f >= 2 * H) && (f < 18 * H) && (((f - 2 * H) % (2 * H)) >= H);
      exp_fv    = (f == 18 * H);
      exp_press = '0;
      if (exp_fv) begin
        for (int p = 0; p < NP; p++) begin
          for (int b = 0; b < 8; b++) begin
            if (pat[p][b]) hold[p][b]++;
            else hold[p][b] = 0;
            ev = (hold[p][b] == 1) ||
                 (MASK[b] && hold[p][b] >= RD && ((hold[p][b] - RD) % RR) == 0);
            exp_btn[p*8+b]   = pat[p][b];
            exp_press[p*8+b] = ev;
          end
        end
      end
    end
    if (started) begin
      chk("latch", {31'd0, latch}, {31'd0, exp_latch});
      chk("pulse", {31'd0, pulse}, {31'd0, exp_pulse});
      chk("frame_valid", {31'd0, frame_valid}, {31'd0, exp_fv});
      chk("buttons", {16'd0, buttons}, {16'd0, exp_btn});
      chk("press", {16'd0, press}, {16'd0, exp_press});
      if (latch === 1'b1 && pulse === 1'b1) chk("latch_pulse_overlap", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_fv();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_valid !== 1'b1 && n < 400);
    if (frame_valid !== 1'b1) chk("fv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_latch();
    int n = 0;
    while (latch !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (latch !== 1'b1) chk("latch_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] tab4 [8] = '{8'h11, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00};
  logic [7:0] tab5 [3] = '{8'h10, 8'h00, 8'h10};

  initial begin
    reset_n    = 1'b0;
    force_zero = 1'b1;
    pat[0]     = 8'h00;
    pat[1]     = 8'h00;

    // 1: reset held for 5 cycles
    repeat (5) tick();
    chk("reset_latch", {31'd0, latch}, 32'd0);
    chk("reset_buttons", {16'd0, buttons}, 32'd0);

    // 2: release, all buttons up
    reset_n    = 1'b1;
    force_zero = 1'b0;
    tick();
    chk("first_latch_cycle", {31'd0, latch}, 32'd1);
    wait_fv();
    chk("first_fv_cycle", cyc, 32'd73);
    chk("idle_buttons", {16'd0, buttons}, 32'd0);

    // 3: pad0 A, pad1 Right
    pat[0] = 8'h01;
    pat[1] = 8'h80;
    wait_latch();
    chk("second_latch_cycle", cyc, 32'd201);
    wait_fv();
    chk("t3_buttons", {16'd0, buttons}, 32'h8001);
    chk("t3_press", {16'd0, press}, 32'h8001);
    tick();
    chk("t3_press_clear", {16'd0, press}, 32'd0);

    // 4: release all for a frame, then hold pad0 Up+A for 8 frames
    pat[0] = 8'h00;
    pat[1] = 8'h00;
    wait_fv();
    pat[0] = 8'h11;
    for (int k = 0; k < 8; k++) begin
      wait_fv();
      chk($sformatf("t4_press_f%0d", k + 1), {24'd0, press[7:0]}, {24'd0, tab4[k]});
    end

    // 5: release Up for one frame, then re-press
    pat[0] = 8'h01;
    wait_fv();
    chk("t5_release_buttons", {24'd0, buttons[7:0]}, 32'h01);
    chk("t5_release_press", {16'd0, press}, 32'd0);
    pat[0] = 8'h11;
    for (int k = 0; k < 3; k++) begin
      wait_fv();
      chk($sformatf("t5_press_f%0d", k + 1), {24'd0, press[7:0]}, {24'd0, tab5[k]});
    end

    // 6: reset during pulse-high of bit 3, pad0 A held
    pat[0] = 8'h01;
    wait_latch();
    repeat (37) tick();
    chk("t6_pulse_before", {31'd0, pulse}, 32'd1);
    reset_n = 1'b0;
    tick();
    chk("t6_pulse_abort", {31'd0, pulse}, 32'd0);
    chk("t6_buttons_abort", {16'd0, buttons}, 32'd0);
    chk("t6_fv_abort", {31'd0, frame_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    wait_fv();
    chk("t6_fv_cycle", cyc, 32'd73);
    chk("t6_buttons", {16'd0, buttons}, 32'h0001);
    chk("t6_press", {16'd0, press}, 32'h0001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
